// File: rtl/nfc_ask_demod.sv
// ASK demodulator for the filtered NFC carrier: rectify, peak-hold envelope, hysteretic slice,
// debounce FSM and run-length measurement. Define NFC_ASK_DEMOD_STATS_EN to add edge/glitch counters.
module nfc_ask_demod #(
  parameter int unsigned IN_WIDTH    = 25,
  parameter int unsigned DECAY_SHIFT = 6,
  parameter int unsigned TH_HI       = 2 ** (IN_WIDTH - 3),
  parameter int unsigned TH_LO       = 2 ** (IN_WIDTH - 4),
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned RUN_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_WIDTH-1:0] v_hpf,
  output logic [IN_WIDTH-2:0]        env_out,
  output logic                       demod_bit,
  // `edge` is a reserved word, so the transition strobe is edge_strobe.
  output logic                       edge_strobe,
  output logic [RUN_WIDTH-1:0]       run_len,
  output logic                       run_valid
`ifdef NFC_ASK_DEMOD_STATS_EN
  ,
  output logic [15:0]                edge_count,
  output logic [15:0]                glitch_count
`endif
);

  localparam int unsigned AW = IN_WIDTH - 1;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  localparam logic [AW-1:0]        TH_HI_V  = AW'(TH_HI);
  localparam logic [AW-1:0]        TH_LO_V  = AW'(TH_LO);
  localparam logic [AW-1:0]        MAG_MAX  = {AW{1'b1}};
  localparam logic [CW-1:0]        CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [RUN_WIDTH-1:0] RUN_MAX  = {RUN_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_PEND_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_PEND_LOW  = 2'd3
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [RUN_WIDTH-1:0]   run_cnt;

  logic [IN_WIDTH-1:0]    neg_c;
  logic [AW-1:0]          mag_c;
  logic [AW-1:0]          dec_c;
  logic [AW-1:0]          env_nxt_c;
  logic                   hi_c;
  logic                   lo_c;
  logic                   rise_c;
  logic                   fall_c;
  logic                   abort_c;
  logic                   take_c;
  logic [RUN_WIDTH-1:0]   run_inc_c;

  // Rectifier; the most negative code has no positive twin and clamps to full scale.
  always_comb begin
    neg_c = ~v_hpf + IN_WIDTH'(1);
    mag_c = v_hpf[AW-1:0];
    if (v_hpf[IN_WIDTH-1]) begin
      mag_c = neg_c[IN_WIDTH-1] ? MAG_MAX : neg_c[AW-1:0];
    end
  end

  // Peak hold with exponential droop; the subtraction cannot underflow.
  always_comb begin
    dec_c     = env_out - (env_out >> DECAY_SHIFT);
    env_nxt_c = (mag_c > dec_c) ? mag_c : dec_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_out <= '0;
    end else begin
      env_out <= env_nxt_c;
    end
  end

  assign hi_c = env_out > TH_HI_V;
  assign lo_c = env_out < TH_LO_V;

  // Accept/abort decode for the current debounce state.
  always_comb begin
    rise_c  = 1'b0;
    fall_c  = 1'b0;
    abort_c = 1'b0;
    unique case (state)
      S_LOW:       rise_c = hi_c && (DEBOUNCE == 1);
      S_PEND_HIGH: begin
        rise_c  = hi_c && (cnt == CNT_LAST);
        abort_c = !hi_c;
      end
      S_HIGH:      fall_c = lo_c && (DEBOUNCE == 1);
      S_PEND_LOW:  begin
        fall_c  = lo_c && (cnt == CNT_LAST);
        abort_c = !lo_c;
      end
      default: ;
    endcase
    take_c = rise_c | fall_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOW;
      cnt       <= '0;
      demod_bit <= 1'b0;
    end else begin
      unique case (state)
        S_LOW: begin
          if (rise_c) begin
            state     <= S_HIGH;
            demod_bit <= 1'b1;
          end else if (hi_c) begin
            state <= S_PEND_HIGH;
            cnt   <= CW'(1);
          end
        end
        S_PEND_HIGH: begin
          if (rise_c) begin
            state     <= S_HIGH;
            cnt       <= '0;
            demod_bit <= 1'b1;
          end else if (abort_c) begin
            state <= S_LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (fall_c) begin
            state     <= S_LOW;
            demod_bit <= 1'b0;
          end else if (lo_c) begin
            state <= S_PEND_LOW;
            cnt   <= CW'(1);
          end
        end
        S_PEND_LOW: begin
          if (fall_c) begin
            state     <= S_LOW;
            cnt       <= '0;
            demod_bit <= 1'b0;
          end else if (abort_c) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Run length: the accepting cycle is counted as part of the run it closes.
  assign run_inc_c = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + RUN_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt     <= '0;
      run_len     <= '0;
      run_valid   <= 1'b0;
      edge_strobe <= 1'b0;
    end else begin
      edge_strobe <= take_c;
      run_valid   <= take_c;
      if (take_c) begin
        run_len <= run_inc_c;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_inc_c;
      end
    end
  end

`ifdef NFC_ASK_DEMOD_STATS_EN
  // Edge count wraps; glitch count sticks at full scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_count   <= '0;
      glitch_count <= '0;
    end else begin
      if (take_c) begin
        edge_count <= edge_count + 16'd1;
      end
      if (abort_c && (glitch_count != 16'hFFFF)) begin
        glitch_count <= glitch_count + 16'd1;
      end
    end
  end
`else
  logic unused_abort_c;
  assign unused_abort_c = abort_c;
`endif

endmodule

// File: tb/tb_nfc_ask_demod.sv
// Directed bench for nfc_ask_demod: expected transitions are queued when stimulus is driven
// and checked against each edge strobe; envelope and level are checked at directed points.
module tb_nfc_ask_demod;

  localparam int unsigned IW = 16;
  localparam int unsigned RW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [IW-1:0] v_hpf;
  logic [IW-2:0]        env_out;
  logic                 demod_bit;
  logic                 edge_strobe;
  logic [RW-1:0]        run_len;
  logic                 run_valid;
`ifdef NFC_ASK_DEMOD_STATS_EN
  logic [15:0]          edge_count;
  logic [15:0]          glitch_count;
`endif

  nfc_ask_demod #(
    .IN_WIDTH    (IW),
    .DECAY_SHIFT (4),
    .TH_HI       (1000),
    .TH_LO       (800),
    .DEBOUNCE    (3),
    .RUN_WIDTH   (RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .v_hpf        (v_hpf),
    .env_out      (env_out),
    .demod_bit    (demod_bit),
    .edge_strobe  (edge_strobe),
    .run_len      (run_len),
    .run_valid    (run_valid)
`ifdef NFC_ASK_DEMOD_STATS_EN
    ,
    .edge_count   (edge_count),
    .glitch_count (glitch_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   at;
    logic level;
    int   len;
  } ev_t;

  ev_t exp_q[$];
  int  checks    = 0;
  int  passed    = 0;
  int  fails     = 0;
  int  last_edge = 0;
  int  dec_exp[7] = '{1125, 1055, 990, 929, 871, 817, 766};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_len(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Queue a transition expected `delay` posedges after the next one is counted.
  task automatic expect_edge(input int delay, input logic level);
    ev_t e;
    e.at      = cyc + delay;
    e.level   = level;
    e.len     = sat_len(e.at - last_edge);
    last_edge = e.at;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Edge monitor: every strobe must match the oldest queued transition.
  always @(negedge clk) begin
    if (!rst && (edge_strobe || run_valid)) begin
      check("strobe_pair", 32'(run_valid), 32'(edge_strobe));
      if (edge_strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_edge", 32'(edge_strobe), 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("edge_cycle", cyc, e.at);
          check("edge_level", 32'(demod_bit), 32'(e.level));
          check("edge_run_len", 32'(run_len), e.len);
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    v_hpf = '0;
    tick(2);
    check("rst_env", 32'(env_out), 0);
    check("rst_bit", 32'(demod_bit), 0);
    check("rst_edge", 32'(edge_strobe), 0);
    check("rst_len", 32'(run_len), 0);
    check("rst_valid", 32'(run_valid), 0);
    rst       = 1'b0;
    last_edge = cyc;

    // Rise on a constant +1200
    v_hpf = 16'sd1200;
    expect_edge(4, 1'b1);
    tick(1);
    check("rise_env", 32'(env_out), 1200);
    check("rise_pre", 32'(demod_bit), 0);
    tick(2);
    check("rise_hold", 32'(demod_bit), 0);
    tick(1);
    check("rise_bit", 32'(demod_bit), 1);
    check("rise_edge", 32'(edge_strobe), 1);

    // Decay and fall
    v_hpf = '0;
    expect_edge(10, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check("decay_env", 32'(env_out), dec_exp[i]);
    end
    check("fall_hold0", 32'(demod_bit), 1);
    tick(2);
    check("fall_hold2", 32'(demod_bit), 1);
    tick(1);
    check("fall_bit", 32'(demod_bit), 0);

    // Negative input rectifies to the same envelope
    v_hpf = -16'sd1200;
    expect_edge(4, 1'b1);
    tick(1);
    check("neg_env", 32'(env_out), 1200);
    tick(3);
    check("neg_bit", 32'(demod_bit), 1);
    v_hpf = '0;
    expect_edge(10, 1'b0);
    tick(10);
    check("neg_fall_bit", 32'(demod_bit), 0);

    // Glitch: two qualifying cycles, then back into the band
    v_hpf = 16'sd1010;
    tick(1);
    check("glitch_env0", 32'(env_out), 1010);
    tick(1);
    check("glitch_env1", 32'(env_out), 1010);
    v_hpf = 16'sd900;
    tick(1);
    check("glitch_env2", 32'(env_out), 947);
    tick(1);
    check("glitch_env3", 32'(env_out), 900);
    tick(4);
    check("glitch_bit", 32'(demod_bit), 0);
`ifdef NFC_ASK_DEMOD_STATS_EN
    check("glitch_count", 32'(glitch_count), 1);
`endif
    v_hpf = '0;
    tick(30);

    // Edges 200 cycles apart
    v_hpf = 16'sd1200;
    expect_edge(4, 1'b1);
    tick(4);
    tick(190);
    v_hpf = '0;
    expect_edge(10, 1'b0);
    tick(10);
    check("run200", 32'(run_len), 200);
    tick(5);
    check("run200_hold", 32'(run_len), 200);
    check("run200_valid", 32'(run_valid), 0);

    // Edges 400 cycles apart saturate
    tick(391);
    v_hpf = 16'sd1200;
    expect_edge(4, 1'b1);
    tick(4);
    check("run_sat", 32'(run_len), 255);

    // Most negative code clamps
    v_hpf = 16'sh8000;
    tick(1);
    check("clamp_env", 32'(env_out), 32767);
    check("clamp_bit", 32'(demod_bit), 1);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    check("arst_env", 32'(env_out), 0);
    check("arst_bit", 32'(demod_bit), 0);
    check("arst_edge", 32'(edge_strobe), 0);
    check("arst_len", 32'(run_len), 0);
    check("arst_valid", 32'(run_valid), 0);
    exp_q.delete();
    v_hpf = '0;
    tick(2);
    rst       = 1'b0;
    last_edge = cyc;
    tick(1);
    check("post_rst_bit", 32'(demod_bit), 0);
    check("post_rst_env", 32'(env_out), 0);
    v_hpf = 16'sd1200;
    expect_edge(4, 1'b1);
    tick(4);
    check("post_rst_rise", 32'(demod_bit), 1);
`ifdef NFC_ASK_DEMOD_STATS_EN
    check("edge_count", 32'(edge_count), 1);
`endif
    tick(2);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/nfc_ask_demod.md
Name: nfc_ask_demod

Overview:
Digital ASK demodulator placed directly downstream of the NFC high-pass filter stage. It consumes the filtered signed fixed-point voltage v_hpf (13.56 MHz carrier with ASK amplitude modulation) and produces a clean demodulated bit stream.
- Processing chain: rectification, peak-hold envelope with exponential decay, hysteretic slicing, debounce FSM, run-length measurement.
- Outputs feed the downstream bit decoder and the analog probe infrastructure.

Parameters:
- IN_WIDTH, 25: bit width of signed fixed-point v_hpf.
- DECAY_SHIFT, 6: envelope decay per cycle is env >> DECAY_SHIFT. Legal range 1..IN_WIDTH-2.
- TH_HI, 2**(IN_WIDTH-3): envelope level, in input LSBs, above which the level qualifies as high.
- TH_LO, 2**(IN_WIDTH-4): envelope level below which the level qualifies as low. Must satisfy TH_LO < TH_HI.
- DEBOUNCE, 4: number of consecutive qualifying cycles required to accept a transition. Must be ≥1.
- RUN_WIDTH, 16: width of the run-length counter.

Ports:
- clk, in, 1: system/emulator clock. All state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- v_hpf, in, IN_WIDTH: signed fixed-point filtered voltage.
- env_out, out, IN_WIDTH-1: unsigned envelope register.
- demod_bit, out, 1: accepted demodulated level.
- edge, out, 1: one-cycle strobe on each accepted transition. New level is visible on demod_bit in the same cycle.
- run_len, out, RUN_WIDTH: length in cycles of the level just ended.
- run_valid, out, 1: one-cycle strobe qualifying run_len. Asserted coincident with edge.

Behaviour:
- Reset: while rst=1, every register and output is 0 immediately (asynchronous). This includes env_out, demod_bit, edge, run_len, run_valid, FSM=LOW, debounce count and run counter. Reset asserted mid-transition discards any pending count.
- Rectify (combinational): abs = |v_hpf|. The most negative input saturates to 2**(IN_WIDTH-1)-1.
- Envelope (1-cycle latency): dec = env - (env >> DECAY_SHIFT), using a logical shift on the unsigned value. env_next = max(abs, dec).
  - env never wraps.
  - env=0 with abs=0 holds at 0.
- Comparison uses the registered env. Strict compares: hi_q = env > TH_HI, lo_q = env < TH_LO.
- FSM states: LOW, PEND_HIGH, HIGH, PEND_LOW. Debounce count cnt is 0..DEBOUNCE.
  - LOW: if hi_q, go to PEND_HIGH with cnt=1. If DEBOUNCE=1, go directly to HIGH instead.
  - PEND_HIGH: if hi_q, cnt++. When cnt reaches DEBOUNCE, go to HIGH. If not hi_q, return to LOW with cnt=0; no edge is produced.
  - HIGH and PEND_LOW: symmetric, using lo_q.
  - An env value inside the hysteresis band (TH_LO..TH_HI) counts as non-qualifying in both pending states.
  - demod_bit=1 in HIGH and PEND_LOW, 0 in LOW and PEND_HIGH. It changes only on the accepted-transition cycle.
- Edge timing: demod_bit toggles and edge=1 in the cycle registered DEBOUNCE cycles after env first qualifies.
- Run counter run_cnt:
  - Increments every cycle and saturates at 2**RUN_WIDTH-1.
  - On an accepted transition: run_len <= sat(run_cnt+1), run_valid=1, run_cnt <= 0.
  - Result: two edges N cycles apart give run_len=N.
  - run_len holds its value between strobes.
- Simultaneous events: reset dominates everything. A saturated run_cnt coincident with an edge reports the maximum value and clears.

Optional Feature:
NFC_ASK_DEMOD_STATS_EN
- When defined, adds two outputs:
  - edge_count [15:0]: counts accepted transitions, wraps at 2^16.
  - glitch_count [15:0]: counts aborted pending states (PEND_*→origin), saturates at 0xFFFF.
  - Both are cleared by rst.
- When undefined, neither port nor counter exists, and all other behaviour is identical.

Test Plan:
Configuration for all scenarios: IN_WIDTH=16, DECAY_SHIFT=4, TH_HI=1000, TH_LO=800, DEBOUNCE=3, RUN_WIDTH=8.
- Reset: assert rst asynchronously mid-simulation → all outputs 0 within the same timestep, with no clock required. Release → FSM in LOW.
- Rise: drive v_hpf=1200 constant → env_out=1200 one cycle later. demod_bit rises and edge=1 exactly 3 cycles after env first reads 1200.
- Rectify: v_hpf=-1200 gives the same result as +1200. v_hpf=-32768 → env_out=32767.
- Decay/fall: from HIGH with env=1200, drive v_hpf=0 → env sequence 1125, 1055, 990, 929, 871, 817, 766. demod_bit falls 3 cycles after env reads 766.
- Glitch: env >1000 for 2 cycles, then 900 → no edge and demod_bit stays 0. With STATS_EN, glitch_count increments by 1.
- Run length: accepted edges 200 cycles apart → run_valid pulse with run_len=200. Edges 400 cycles apart → run_len=255 (saturated).
